// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Requester-side controller for the pipeline MEM stage. Takes one load or store
// at a time over a valid/ready handshake and drives a simple 32-bit word memory
// (combinational read, write on the rising edge while mem_wmem is high).
// Sub-word stores are done as read-modify-write. Sub-word loads are sign- or
// zero-extended. A programmable wait counter models memory latency.
//
// Parameters
//   MEM_WORDS    memory depth in 32-bit words; byte addresses at or above
//                MEM_WORDS*4 are out of range
//   WAIT_CYCLES  extra cycles spent in WAIT before each access (0..255)
//
// Ports
//   clock       rising-edge clock for all state
//   resetn      asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller idle; accept on req_valid & req_ready at an edge
//   req_we      1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle completion pulse
//   rsp_err     error flag, valid with rsp_valid
//   rsp_rdata   extended load result, held until the next load response
//   mem_addr    word-aligned byte address to memory (0 while idle)
//   mem_wmem    memory write enable
//   mem_wdata   word written to memory
//   mem_rdata   combinational read data for mem_addr
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wmem,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // One bit wider than the address so the limit itself is representable.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;
  localparam logic [7:0]  WAIT_INIT  = 8'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wbuf_q;     // store data, becomes the merged word after READ
  logic        err_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;

  // Word stores need no read; everything else starts with a READ.
  function automatic state_t first_access(input logic we, input logic [1:0] size);
    return (we && size == SZ_WORD) ? S_WRITE : S_READ;
  endfunction

  // Replace the addressed lane of the memory word with right-aligned data.
  function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0: w[7:0]   = new_data[7:0];
          2'd1: w[15:8]  = new_data[7:0];
          2'd2: w[23:16] = new_data[7:0];
          default: w[31:24] = new_data[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) w[31:16] = new_data[15:0];
        else         w[15:0]  = new_data[15:0];
      end
      default: w = new_data;
    endcase
    return w;
  endfunction

  // Select the addressed lane and extend it to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      SZ_HALF: r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept = req_valid && (state_q == S_IDLE);

  assign req_err = (req_size == 2'b11)
                || (req_size == SZ_HALF && req_addr[0])
                || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                || ({1'b0, req_addr} >= ADDR_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the block order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case; without it any path that
  // leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_err)                state_d = S_RESP;
          else if (WAIT_INIT != 8'd0) state_d = S_WAIT;
          else                        state_d = first_access(req_we, req_size);
        end
      end
      S_WAIT:  if (cnt_q <= 8'd1) state_d = first_access(we_q, size_q);
      S_READ:  state_d = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, because the outputs built from
  // them have defined values straight out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wbuf_q   <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
      rdata_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wbuf_q   <= req_wdata;
        err_q    <= req_err;
        cnt_q    <= WAIT_INIT;
      end

      // Counter saturates at zero rather than wrapping.
      if (state_q == S_WAIT && cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;

      if (state_q == S_READ) begin
        if (we_q) wbuf_q  <= merge_lane(mem_rdata, wbuf_q, size_q, addr_q[1:0]);
        else      rdata_q <= extract_lane(mem_rdata, size_q, addr_q[1:0], signed_q);
      end
    end
  end

  // Outputs are decoded from state so reset removes them asynchronously.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_err   = (state_q == S_RESP) && err_q;
  assign rsp_rdata = rdata_q;
  assign mem_wmem  = (state_q == S_WRITE);
  assign mem_addr  = (state_q == S_IDLE) ? 32'd0 : {addr_q[31:2], 2'b00};
  assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. dut0 runs with WAIT_CYCLES=0 and owns the
// write port of the shared word memory model; dut1 runs with WAIT_CYCLES=3 and
// only reads it. Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int MEM_WORDS = 1024;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  always #5 clock = ~clock;

  logic        req_valid0, req_valid1;
  logic        req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready0, rsp_valid0, rsp_err0, mem_wmem0;
  logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        req_ready1, rsp_valid1, rsp_err1, mem_wmem1;
  logic [31:0] rsp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_err(rsp_err0), .rsp_rdata(rsp_rdata0),
    .mem_addr(mem_addr0), .mem_wmem(mem_wmem0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0)
  );

  mem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .WAIT_CYCLES(3)) dut1 (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_err(rsp_err1), .rsp_rdata(rsp_rdata1),
    .mem_addr(mem_addr1), .mem_wmem(mem_wmem1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  // Word memory model: combinational read, write at the rising edge.
  logic [31:0] mem [0:MEM_WORDS-1];
  logic        tb_we = 1'b0;
  logic [9:0]  tb_idx = '0;
  logic [31:0] tb_val = '0;

  assign mem_rdata0 = mem[mem_addr0[11:2]];
  assign mem_rdata1 = mem[mem_addr1[11:2]];

  always @(posedge clock) begin
    if (mem_wmem0) mem[mem_addr0[11:2]] <= mem_wdata0;
    else if (tb_we) mem[tb_idx] <= tb_val;
  end

  // Observed signals of the selected DUT.
  logic        sel = 1'b0;
  logic        obs_ready, obs_valid, obs_err, obs_wmem;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  assign obs_ready = sel ? req_ready1 : req_ready0;
  assign obs_valid = sel ? rsp_valid1 : rsp_valid0;
  assign obs_err   = sel ? rsp_err1   : rsp_err0;
  assign obs_wmem  = sel ? mem_wmem1  : mem_wmem0;
  assign obs_rdata = sel ? rsp_rdata1 : rsp_rdata0;
  assign obs_addr  = sel ? mem_addr1  : mem_addr0;
  assign obs_wdata = sel ? mem_wdata1 : mem_wdata0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    tb_idx = idx;
    tb_val = val;
    tb_we  = 1'b1;
    @(posedge clock); #1;
    tb_we  = 1'b0;
  endtask

  // Results of the last transaction.
  int          lat, wcount, wcycle;
  logic        got_err;
  logic [31:0] got_rdata, waddr, wdata_seen;

  // Issue one request (called 1 unit after an edge, DUT idle), scramble the
  // request inputs after acceptance, then follow it to its response.
  task automatic run_req(input string name, input logic which, input logic we,
                         input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err);
    int ready_seen;
    sel        = which;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    if (which) req_valid1 = 1'b1;
    else       req_valid0 = 1'b1;
    check({name, " ready"}, 32'(obs_ready), 32'd1);
    @(posedge clock); #1;
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
    req_we     = ~we;
    req_size   = 2'b11;
    req_signed = ~sgn;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    lat = 99; wcount = 0; wcycle = 0; ready_seen = 0;
    got_err = 1'b0; got_rdata = '0; waddr = '0; wdata_seen = '0;
    for (int k = 1; k <= 20; k++) begin
      if (obs_wmem) begin
        wcount++;
        wcycle     = k;
        waddr      = obs_addr;
        wdata_seen = obs_wdata;
      end
      if (obs_ready) ready_seen++;
      if (obs_valid) begin
        lat       = k;
        got_err   = obs_err;
        got_rdata = obs_rdata;
        break;
      end
      @(posedge clock); #1;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " err"}, 32'(got_err), 32'(exp_err));
    check({name, " ready low"}, 32'(ready_seen), 32'd0);
    @(posedge clock); #1;
    check({name, " ready after"}, 32'(obs_ready), 32'd1);
    check({name, " valid after"}, 32'(obs_valid), 32'd0);
  endtask

  initial begin
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    resetn = 1'b0;
    @(posedge clock); #1;
    poke(10'd8,  32'h1122_3344);
    poke(10'd12, 32'h80FF_7F01);

    // Reset values.
    check("rst req_ready", 32'(req_ready0), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rst rsp_err",   32'(rsp_err0),   32'd0);
    check("rst rsp_rdata", rsp_rdata0, 32'h0);
    check("rst mem_addr",  mem_addr0,  32'h0);
    check("rst mem_wmem",  32'(mem_wmem0),  32'd0);
    check("rst mem_wdata", mem_wdata0, 32'h0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Word store then word load.
    run_req("st_w", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2, 1'b0);
    check("st_w wcount", 32'(wcount), 32'd1);
    check("st_w waddr",  waddr, 32'h10);
    check("st_w wdata",  wdata_seen, 32'hDEAD_BEEF);
    check("st_w mem",    mem[4], 32'hDEAD_BEEF);
    run_req("ld_w", 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0);
    check("ld_w rdata",  got_rdata, 32'hDEAD_BEEF);
    check("ld_w wcount", 32'(wcount), 32'd0);

    // Byte store RMW: one READ cycle, then the write.
    run_req("st_b", 1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA, 3, 1'b0);
    check("st_b wcount", 32'(wcount), 32'd1);
    check("st_b wcycle", 32'(wcycle), 32'd2);
    check("st_b waddr",  waddr, 32'h20);
    check("st_b wdata",  wdata_seen, 32'h11AA_3344);
    check("st_b mem",    mem[8], 32'h11AA_3344);

    // Sub-word loads from 0x80FF7F01.
    run_req("ld_sb31", 1'b0, 1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 2, 1'b0);
    check("ld_sb31 rdata", got_rdata, 32'h0000_007F);
    run_req("ld_sb33", 1'b0, 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 2, 1'b0);
    check("ld_sb33 rdata", got_rdata, 32'hFFFF_FF80);
    run_req("ld_uh32", 1'b0, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 2, 1'b0);
    check("ld_uh32 rdata", got_rdata, 32'h0000_80FF);
    run_req("ld_sh32", 1'b0, 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 2, 1'b0);
    check("ld_sh32 rdata", got_rdata, 32'hFFFF_80FF);

    // Errors: response next cycle, no write, rsp_rdata unchanged.
    run_req("err_w06", 1'b0, 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 1'b1);
    check("err_w06 rdata",  got_rdata, 32'hFFFF_80FF);
    check("err_w06 wcount", 32'(wcount), 32'd0);
    run_req("err_h05", 1'b0, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0, 1, 1'b1);
    check("err_h05 rdata",  got_rdata, 32'hFFFF_80FF);
    check("err_h05 wcount", 32'(wcount), 32'd0);
    run_req("err_sz3", 1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h1234_5678, 1, 1'b1);
    check("err_sz3 rdata",  got_rdata, 32'hFFFF_80FF);
    check("err_sz3 wcount", 32'(wcount), 32'd0);
    check("err_sz3 mem",    mem[4], 32'hDEAD_BEEF);
    run_req("err_oor", 1'b0, 1'b0, 2'b00, 1'b0, 32'(MEM_WORDS * 4), 32'h0, 1, 1'b1);
    check("err_oor rdata",  got_rdata, 32'hFFFF_80FF);
    check("err_oor wcount", 32'(wcount), 32'd0);

    // WAIT_CYCLES = 3 word load.
    run_req("ld_w3", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 1'b0);
    check("ld_w3 rdata",  got_rdata, 32'hDEAD_BEEF);
    check("ld_w3 wcount", 32'(wcount), 32'd0);

    // Reset during the WRITE cycle of a byte store.
    sel = 1'b0;
    req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h0000_0055;
    req_valid0 = 1'b1;
    @(posedge clock); #1;
    req_valid0 = 1'b0;
    wcycle = 0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_wmem0) begin
        wcycle = k;
        break;
      end
      @(posedge clock); #1;
    end
    check("rstw reached write", 32'(wcycle), 32'd2);
    resetn = 1'b0;
    #1;
    check("rstw mem_wmem",  32'(mem_wmem0),  32'd0);
    check("rstw req_ready", 32'(req_ready0), 32'd1);
    check("rstw rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rstw rsp_err",   32'(rsp_err0),   32'd0);
    check("rstw rsp_rdata", rsp_rdata0, 32'h0);
    check("rstw mem_addr",  mem_addr0,  32'h0);
    check("rstw mem_wdata", mem_wdata0, 32'h0);
    lat = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      if (rsp_valid0) lat++;
    end
    check("rstw no rsp", 32'(lat), 32'd0);
    check("rstw mem",    mem[8], 32'h11AA_3344);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Recovery after reset: the untouched word reads back.
    run_req("ld_post", 1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0);
    check("ld_post rdata", got_rdata, 32'h11AA_3344);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Requester-side controller for the pipeline's MEM stage, driving the simple 32-bit word memory (combinational read, write on rising edge when write-enable is high). Accepts one load or store at a time from the pipeline via a valid/ready handshake. Performs byte/halfword/word accesses, using read-modify-write for sub-word stores and sign/zero extension for sub-word loads. Returns a single-cycle response pulse and models memory latency with a programmable wait counter.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; byte addresses ≥ MEM_WORDS*4 are out of range.
- WAIT_CYCLES, 0: extra cycles inserted before each memory access (0..255).

- clock  in  1  rising-edge clock for all state.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request present.
- req_ready  out  1  controller idle; a request is accepted when req_valid & req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; misaligned, illegal size or out of range.
- rsp_rdata  out  32  load result, extended; held until the next load response.
- mem_addr  out  32  word-aligned byte address to memory ({addr[31:2],2'b00}).
- mem_wmem  out  1  memory write enable.
- mem_wdata  out  32  word written to memory.
- mem_rdata  in  32  combinational memory read data for mem_addr.

## Operation
- States: IDLE, WAIT, READ, WRITE, RESP. req_ready = (state == IDLE).
- On accept: latch we, size, signed, addr and wdata; load the wait counter with WAIT_CYCLES.
- Error check at accept: half with addr[0]=1, word with addr[1:0]≠0, size 11, or addr ≥ MEM_WORDS*4 → go directly to RESP with rsp_err=1. No memory access; mem_wmem stays 0 and rsp_rdata is unchanged.
- Otherwise go to WAIT if WAIT_CYCLES > 0, else to the first access state. WAIT decrements the counter and exits when the counter reaches 1.
- Access sequence:
  - Load: READ → RESP.
  - Word store: WRITE → RESP.
  - Byte/half store: READ → WRITE → RESP.
- READ: mem_addr is driven. At the ending edge, capture mem_rdata.
  - Load: select the lane, extend it, write rsp_rdata.
  - Store: merge the new lane into the captured word, forming the write word.
- Lanes are little-endian: byte n = bits [8n+7:8n] with n = addr[1:0]; half = bits [16h+15:16h] with h = addr[1].
- WRITE: mem_wmem=1 for exactly one cycle, with mem_addr and mem_wdata stable for the whole cycle.
  - Word store: mem_wdata = latched wdata.
  - Sub-word store: mem_wdata = the merged word.
- RESP: rsp_valid=1 for one cycle, then return to IDLE. rsp_err=0 for legal accesses.
- mem_addr holds the latched address outside IDLE and is 0 in IDLE. mem_wmem is decoded from state only.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_addr 0, mem_wmem 0, mem_wdata 0, counter 0.
- Latency is counted from the accept edge E0, with W = WAIT_CYCLES:
  - Load: rsp_valid high in cycle 2+W after E0.
  - Word store: rsp_valid high in cycle 2+W after E0.
  - Sub-word store: rsp_valid high in cycle 3+W after E0.
  - Error: rsp_valid high in the cycle immediately after E0.
- req_ready returns to 1 in the cycle after RESP. Back-to-back requests therefore have one IDLE cycle between them.
- Request inputs are ignored outside IDLE. Changing them mid-operation has no effect.
- Asynchronous reset mid-operation forces IDLE immediately and drops mem_wmem combinationally. A write already committed at an earlier edge remains in memory; no response is issued.
- Wait counter is 8 bits and never wraps; WAIT_CYCLES=0 bypasses WAIT entirely.

## Test plan
- Word store then load, W=0: store 0xDEADBEEF @0x10, then load word @0x10.
  - Store: mem_wmem high for one cycle with mem_addr 0x10.
  - Load: rsp_rdata 0xDEADBEEF, rsp_valid 2 cycles after accept, rsp_err 0.
- Byte store RMW with memory word @0x20 = 0x11223344: store byte 0xAA @0x22.
  - Required: one READ cycle, then a write of 0x11AA3344; rsp_valid 3 cycles after accept.
- Sub-word loads from word 0x80FF7F01 @0x30:
  - signed byte @0x31 → 0x0000007F;
  - signed byte @0x33 → 0xFFFFFF80;
  - unsigned half @0x32 → 0x000080FF;
  - signed half @0x32 → 0xFFFF80FF.
- Errors: word load @0x06, half @0x05, size 11, and byte @MEM_WORDS*4.
  - Each: rsp_valid and rsp_err 1 cycle after accept, mem_wmem never asserted, rsp_rdata unchanged.
- WAIT_CYCLES=3, load word: rsp_valid 5 cycles after accept; req_ready 0 throughout, 1 in the following cycle.
- Reset asserted during the WRITE cycle of a byte store: mem_wmem falls immediately, no rsp_valid, outputs take reset values, memory word unchanged.
